hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage forwarding/stall logic.
- A per-register scoreboard records, for every in-flight writer, the pipeline latch it currently occupies and the first latch that holds its result.
- From this it produces per-source forward selects, a load-use/multi-cycle stall, and branch-in-decode forwarding, for any pipeline depth and any source count.
- Sits beside decode. Issue is driven from the decode outputs; the selects drive the EX operand muxes and the decode branch comparator muxes.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- AW, 5, register address width.
- DEPTH, 3, post-decode pipeline latches (1=ID/EX, 2=EX/MEM, 3=MEM/WB).
- NUM_SRC, 2, source operand channels per decoded instruction.
- LW, 2, latch index width; must satisfy 2^LW > DEPTH.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_hold  in  1  global pipeline freeze; scoreboard does not advance
- i_flush  in  1  kill the instruction in ID/EX and the one in decode
- i_issue_valid  in  1  decode instruction writes a register
- i_issue_rd  in  AW  destination of the decode instruction
- i_issue_k  in  LW  first latch holding its result (ALU=2, load=3), range 1..DEPTH
- i_src_addr  in  NUM_SRC*AW  packed source addresses of the decode instruction
- i_src_used  in  NUM_SRC  per-source valid
- i_dec_branch  in  1  decode instruction resolves a branch/jump in decode
- o_fwd_sel  out  NUM_SRC*LW  per source: 0=register file, n=take from latch n
- o_stall  out  1  hold fetch/decode and insert a bubble into ID/EX
- o_busy  out  1  any entry valid
- o_stall_cycles  out  CNT_W  saturating count of cycles with o_stall=1

Behaviour:
- State per register r (r≠0): valid v[r], current latch s[r] (1..DEPTH), result latch k[r].
- Reset (async, rst_n=0): all v=0, o_stall_cycles=0. Consequently o_fwd_sel=0, o_stall=0, o_busy=0. Reset mid-operation discards all in-flight state immediately.
- Issue accept: acc = i_issue_valid & ~o_stall & ~i_hold & ~i_flush & (i_issue_rd≠0).
  - On acc at the clock edge: v[rd]<=1, s[rd]<=1, k[rd]<=i_issue_k.
  - This overrides any older entry for the same rd in the same edge; the youngest writer wins.
- Advance: when i_hold=0, each valid entry not being overwritten moves s<=s+1. An entry with s==DEPTH clears v. The register file is write-through, so the value is readable in the same cycle.
- Hold: when i_hold=1, no entry changes and no issue is accepted.
- Flush: i_flush=1 clears every entry with s==1 and blocks issue. Flush takes effect even while i_hold=1 and overrides advance for those entries.
- Per source j (combinational), with a=i_src_addr[j]:
  - Entry not applicable when ~i_src_used[j], a==0, or v[a]==0: sel=0, not stalling.
  - Normal consumer (i_dec_branch=0): operand is needed in EX next cycle, when the producer will be at s+1.
    - s+1>DEPTH: sel=0.
    - s+1>=k: sel=s+1.
    - otherwise: stall.
  - Branch consumer (i_dec_branch=1): operand is needed now.
    - s>=k: sel=s.
    - otherwise: stall.
  - While source j is stalling, its sel=0.
- o_stall = OR over sources of stall_j. It is purely combinational from state and inputs; there is no path from issue back to stall.
- o_busy = OR of all v.
- o_stall_cycles increments each clk with o_stall=1 & ~i_hold, and saturates at all-ones.
- Illegal stimulus: i_issue_k=0 or i_issue_k>DEPTH is illegal; behaviour is unspecified and covered by an assertion only.

Test Plan (DEPTH=3, NUM_SRC=2):
- Reset: issue rd=4,k=3, then assert rst_n=0 asynchronously mid-cycle -> o_busy=0, o_stall=0, o_fwd_sel=0 before the next edge; o_stall_cycles=0.
- ALU back-to-back: issue rd=5,k=2; next cycle src0=5 used -> o_stall=0, sel0=2; following cycle sel0=3; then sel0=0.
- Load-use: issue rd=7,k=3; next cycle src1=7 -> o_stall=1, issue blocked. Next cycle (s=2) -> o_stall=0, sel1=3. o_stall_cycles=1.
- Branch in decode: issue rd=3,k=2; next cycle i_dec_branch=1, src0=3 -> stall (s=1<2). Next cycle -> sel0=2, o_stall=0.
- x0/unused/youngest-wins: issue rd=0 -> o_busy stays 0. src_used=0 on a busy reg -> sel=0, no stall. Issue rd=6 (k=3) then rd=6 (k=2) back-to-back -> consumer sees sel=2, no stall.
- Flush/hold: issue rd=9, then i_flush=1 -> v[9]=0, sel=0. Issue rd=9,k=3 and hold 4 cycles -> s stays 1 and o_stall stays 1 for a src=9 consumer; o_stall_cycles unchanged during the hold.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-side register scoreboard: tracks every in-flight writer's pipeline latch and
// produces operand forward selects, the load-use/multi-cycle stall and a stall counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int LW       = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_hold,
  input  logic                   i_flush,
  input  logic                   i_issue_valid,
  input  logic [AW-1:0]          i_issue_rd,
  input  logic [LW-1:0]          i_issue_k,
  input  logic [NUM_SRC*AW-1:0]  i_src_addr,
  input  logic [NUM_SRC-1:0]     i_src_used,
  input  logic                   i_dec_branch,
  output logic [NUM_SRC*LW-1:0]  o_fwd_sel,
  output logic                   o_stall,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_stall_cycles
);

  logic [NUM_REGS-1:0] r_v;
  logic [LW-1:0]       r_s [NUM_REGS];
  logic [LW-1:0]       r_k [NUM_REGS];
  logic [CNT_W-1:0]    r_stall_cycles;

  logic                  w_acc;
  logic                  w_stall;
  logic [NUM_SRC*LW-1:0] w_fwd_sel;
  logic [AW-1:0]         w_a;
  logic [LW:0]           w_s;
  logic [LW:0]           w_k;

  // Issue handshake: the decode instruction (i_issue_valid) is taken on the edge only
  // when the scoreboard is not stalling, the pipe is not held and decode is not flushed.
  assign w_acc = i_issue_valid & ~w_stall & ~i_hold & ~i_flush & (i_issue_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        r_s[r] <= '0;
        r_k[r] <= '0;
      end
    end else begin
      r_v[0] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_acc && (i_issue_rd == AW'(r))) begin
          r_v[r] <= 1'b1;
          r_s[r] <= LW'(1);
          r_k[r] <= i_issue_k;
        end else if (r_v[r]) begin
          // Flush kills the ID/EX occupant even while the pipe is frozen.
          if (i_flush && (r_s[r] == LW'(1))) begin
            r_v[r] <= 1'b0;
          end else if (!i_hold) begin
            if (r_s[r] == LW'(DEPTH)) r_v[r] <= 1'b0;
            else                      r_s[r] <= r_s[r] + LW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_stall   = 1'b0;
    w_fwd_sel = '0;
    w_a       = '0;
    w_s       = '0;
    w_k       = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_a = i_src_addr[j*AW +: AW];
      if (i_src_used[j] && (w_a != '0) && (int'(w_a) < NUM_REGS) && r_v[w_a]) begin
        w_s = {1'b0, r_s[w_a]};
        w_k = {1'b0, r_k[w_a]};
        if (i_dec_branch) begin
          // Branch compares in decode, so the operand must be available right now.
          if (w_s >= w_k) w_fwd_sel[j*LW +: LW] = w_s[LW-1:0];
          else            w_stall = 1'b1;
        end else if ((w_s + 1'b1) > (LW+1)'(DEPTH)) begin
          w_fwd_sel[j*LW +: LW] = '0;
        end else if ((w_s + 1'b1) >= w_k) begin
          w_fwd_sel[j*LW +: LW] = w_s[LW-1:0] + LW'(1);
        end else begin
          w_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !i_hold && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_fwd_sel      = w_fwd_sel;
  assign o_stall        = w_stall;
  assign o_busy         = |r_v;
  assign o_stall_cycles = r_stall_cycles;

  a_issue_k_legal: assert property (@(posedge clk) disable iff (!rst_n)
    w_acc |-> ((i_issue_k != '0) && (int'(i_issue_k) <= DEPTH)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table for the corner cases, then random
// traffic checked against a pipeline-of-instructions reference model.
module tb_hazard_scoreboard;
  localparam int AW    = 5;
  localparam int LW    = 2;
  localparam int DEPTH = 3;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk, rst_n;
  logic hold, flush, iv, br;
  logic [AW-1:0] rd, src0, src1;
  logic [LW-1:0] k;
  logic [1:0] used;
  logic [2*AW-1:0] src_addr;
  logic [2*LW-1:0] fwd_sel;
  logic stall, busy;
  logic [CNT_W-1:0] stall_cycles;

  assign src_addr = {src1, src0};

  hazard_scoreboard #(.NUM_REGS(32), .AW(AW), .DEPTH(DEPTH), .NUM_SRC(2), .LW(LW),
                      .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_issue_valid(iv),
    .i_issue_rd(rd), .i_issue_k(k), .i_src_addr(src_addr), .i_src_used(used),
    .i_dec_branch(br), .o_fwd_sel(fwd_sel), .o_stall(stall), .o_busy(busy),
    .o_stall_cycles(stall_cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int hold, flush, iv, rd, k, s0, s1, used, br;
    int e_stall, e_sel0, e_sel1, e_busy, e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int h, f, v, r, kk, a0, a1, u, b, es, e0, e1, eb, ec);
    vec_t t;
    t = '{h, f, v, r, kk, a0, a1, u, b, es, e0, e1, eb, ec};
    vecs.push_back(t);
  endtask

  task automatic idle_vec(input int eb, ec);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, eb, ec);
  endtask

  task automatic drive_idle();
    hold = 0; flush = 0; iv = 0; rd = '0; k = LW'(1);
    src0 = '0; src1 = '0; used = '0; br = 0;
  endtask

  // Reference model: a shift register of in-flight instructions; latch n holds the
  // instruction n stages past decode. A register's producer is its youngest tracked copy.
  bit p_v[DEPTH+1];
  int p_rd[DEPTH+1];
  int p_k[DEPTH+1];
  int m_cnt;
  bit m_stall;
  int m_sel[2];

  task automatic model_reset();
    for (int n = 0; n <= DEPTH; n++) begin p_v[n] = 0; p_rd[n] = 0; p_k[n] = 0; end
    m_cnt = 0;
  endtask

  task automatic model_eval();
    int a, pos;
    m_stall = 0;
    for (int j = 0; j < 2; j++) begin
      m_sel[j] = 0;
      a = (j == 0) ? int'(src0) : int'(src1);
      pos = 0;
      for (int n = DEPTH; n >= 1; n--) if (p_v[n] && p_rd[n] == a) pos = n;
      if (used[j] && a != 0 && pos != 0) begin
        if (br) begin
          if (pos >= p_k[pos]) m_sel[j] = pos; else m_stall = 1;
        end else if (pos + 1 > DEPTH) begin
          m_sel[j] = 0;
        end else if (pos + 1 >= p_k[pos]) begin
          m_sel[j] = pos + 1;
        end else begin
          m_stall = 1;
        end
      end
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = iv && !m_stall && !hold && !flush && rd != 0;
    if (flush) p_v[1] = 0;
    if (!hold) begin
      for (int n = DEPTH; n >= 2; n--) begin
        p_v[n] = p_v[n-1]; p_rd[n] = p_rd[n-1]; p_k[n] = p_k[n-1];
      end
      p_v[1] = 0;
      if (acc) begin
        for (int n = 2; n <= DEPTH; n++) if (p_rd[n] == int'(rd)) p_v[n] = 0;
        p_v[1] = 1; p_rd[1] = int'(rd); p_k[1] = int'(k);
      end
    end
    if (m_stall && !hold && m_cnt < CMAX) m_cnt++;
  endtask

  function automatic int model_busy();
    int b = 0;
    for (int n = 1; n <= DEPTH; n++) if (p_v[n]) b = 1;
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    drive_idle();
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    vec_t t;
    rst_n = 1;
    drive_idle();
    #2 rst_n = 0;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_sel", int'(fwd_sel), 0);
    check("reset_cnt", int'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1;

    // Asynchronous reset discards an in-flight load before the next edge.
    @(negedge clk);
    iv = 1; rd = 5'd4; k = 2'd3;
    @(negedge clk);
    drive_idle();
    src0 = 5'd4; used = 2'b01;
    #1;
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_stall", int'(stall), 1);
    #1 rst_n = 0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_stall", int'(stall), 0);
    check("async_rst_sel", int'(fwd_sel), 0);
    check("async_rst_cnt", int'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1;
    drive_idle();

    // ALU back-to-back
    add_vec(0,0,1,5,2, 0,0,0,0, 0,0,0,0,0);
    add_vec(0,0,0,0,1, 5,0,1,0, 0,2,0,1,0);
    add_vec(0,0,0,0,1, 5,0,1,0, 0,3,0,1,0);
    add_vec(0,0,0,0,1, 5,0,1,0, 0,0,0,1,0);
    add_vec(0,0,0,0,1, 5,0,1,0, 0,0,0,0,0);
    // Load-use with a blocked issue of rd=8
    add_vec(0,0,1,7,3, 0,0,0,0, 0,0,0,0,0);
    add_vec(0,0,1,8,2, 0,7,2,0, 1,0,0,1,0);
    add_vec(0,0,0,0,1, 8,7,3,0, 0,0,3,1,1);
    idle_vec(1, 1);
    idle_vec(0, 1);
    // Branch in decode
    add_vec(0,0,1,3,2, 0,0,0,0, 0,0,0,0,1);
    add_vec(0,0,0,0,1, 3,0,1,1, 1,0,0,1,1);
    add_vec(0,0,0,0,1, 3,0,1,1, 0,2,0,1,2);
    add_vec(0,0,0,0,1, 3,0,1,1, 0,3,0,1,2);
    idle_vec(0, 2);
    // x0, unused sources, youngest writer wins
    add_vec(0,0,1,0,2, 0,0,0,0, 0,0,0,0,2);
    idle_vec(0, 2);
    add_vec(0,0,1,6,3, 0,0,0,0, 0,0,0,0,2);
    add_vec(0,0,1,6,2, 6,6,0,0, 0,0,0,1,2);
    add_vec(0,0,0,0,1, 6,0,1,0, 0,2,0,1,2);
    idle_vec(1, 2);
    idle_vec(1, 2);
    idle_vec(0, 2);
    // Flush, then hold with a stalled consumer
    add_vec(0,0,1,9,2, 0,0,0,0, 0,0,0,0,2);
    add_vec(0,1,1,10,2, 9,0,1,0, 0,2,0,1,2);
    add_vec(0,0,0,0,1, 9,10,3,0, 0,0,0,0,2);
    add_vec(0,0,1,9,3, 0,0,0,0, 0,0,0,0,2);
    for (int i = 0; i < 4; i++) add_vec(1,0,0,0,1, 9,0,1,0, 1,0,0,1,2);
    add_vec(0,0,0,0,1, 9,0,1,0, 1,0,0,1,2);
    add_vec(0,0,0,0,1, 9,0,1,0, 0,3,0,1,3);
    idle_vec(1, 3);
    idle_vec(0, 3);
    // Flush while held
    add_vec(0,0,1,11,2, 0,0,0,0, 0,0,0,0,3);
    add_vec(1,1,0,0,1, 11,0,1,0, 0,2,0,1,3);
    add_vec(0,0,0,0,1, 11,0,1,0, 0,0,0,0,3);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      hold = t.hold[0]; flush = t.flush[0]; iv = t.iv[0]; rd = AW'(t.rd); k = LW'(t.k);
      src0 = AW'(t.s0); src1 = AW'(t.s1); used = 2'(t.used); br = t.br[0];
      #1;
      check($sformatf("vec%0d_stall", i), int'(stall), t.e_stall);
      check($sformatf("vec%0d_sel0", i), int'(fwd_sel[LW-1:0]), t.e_sel0);
      check($sformatf("vec%0d_sel1", i), int'(fwd_sel[2*LW-1:LW]), t.e_sel1);
      check($sformatf("vec%0d_busy", i), int'(busy), t.e_busy);
      check($sformatf("vec%0d_cnt", i), int'(stall_cycles), t.e_cnt);
      @(negedge clk);
    end

    // Random traffic against the model; counter is narrow so it saturates here.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      iv    = ($urandom_range(0, 9) < 7);
      rd    = AW'($urandom_range(0, 7));
      k     = LW'($urandom_range(1, DEPTH));
      src0  = AW'($urandom_range(0, 7));
      src1  = AW'($urandom_range(0, 7));
      used  = 2'($urandom_range(0, 3));
      br    = ($urandom_range(0, 3) == 0);
      #1;
      model_eval();
      check("rnd_stall", int'(stall), int'(m_stall));
      check("rnd_sel0", int'(fwd_sel[LW-1:0]), m_sel[0]);
      check("rnd_sel1", int'(fwd_sel[2*LW-1:LW]), m_sel[1]);
      check("rnd_busy", int'(busy), model_busy());
      check("rnd_cnt", int'(stall_cycles), m_cnt);
      model_step();
      @(negedge clk);
    end
    check("rnd_cnt_final", int'(stall_cycles), m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
